// File: rtl/cdma_tx_sequencer.sv
// cdma_tx_sequencer: frame controller for the CDMA spreader datapath.
// Loads the gold seed, then paces chips and presents preamble bits followed by payload bits.
module cdma_tx_sequencer #(
   parameter logic [23:0] CLK_DIV = 24'd10_000_000,
   parameter int CHIPS_PER_BIT = 31,
   parameter int PREAMBLE_BITS = 8,
   parameter int DATA_BITS = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 abort_i,
   input  logic [4:0]           seed_i,
   input  logic [DATA_BITS-1:0] data_i,
   output logic                 seed_load_o,
   output logic [4:0]           seed_o,
   output logic                 chip_en_o,
   output logic                 bit_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 led_o
);
   localparam int MAX_BITS = PREAMBLE_BITS > DATA_BITS ? PREAMBLE_BITS : DATA_BITS;
   localparam int PW = CLK_DIV > 24'd1 ? $clog2(CLK_DIV) : 1;
   localparam int CW = CHIPS_PER_BIT > 1 ? $clog2(CHIPS_PER_BIT) : 1;
   localparam int BW = MAX_BITS > 1 ? $clog2(MAX_BITS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 24'd1);
   localparam logic [CW-1:0] CHIP_LAST = CW'(CHIPS_PER_BIT - 1);
   localparam logic [BW-1:0] PRE_LAST = BW'(PREAMBLE_BITS - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {IDLE, LOAD, PREAMBLE, DATA, DONE} state_t;

   state_t               state;
   logic [PW-1:0]        presc;
   logic [CW-1:0]        chip;
   logic [BW-1:0]        idx;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] shifted;
   logic                 running;
   logic                 tick;
   logic                 bit_end;

   assign running = state == PREAMBLE || state == DATA;
   assign tick = running && presc == PRESC_LAST;
   assign bit_end = tick && chip == CHIP_LAST;
   // Payload is shifted out MSB-first so the next bit is always at the top.
   assign shifted = shift << 1;
   assign chip_en_o = tick;
   assign led_o = bit_o & busy_o;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         presc <= '0;
         chip <= '0;
         idx <= '0;
         shift <= '0;
         seed_o <= '0;
         seed_load_o <= 1'b0;
         bit_o <= 1'b0;
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         seed_load_o <= 1'b0;
         done_o <= 1'b0;
         if (running) presc <= tick ? '0 : presc + 1'b1;
         if (tick) chip <= bit_end ? '0 : chip + 1'b1;
         case (state)
            IDLE: if (start_i && !abort_i) begin
               state <= LOAD;
               seed_o <= seed_i == 5'd0 ? 5'd1 : seed_i;
               shift <= data_i;
               seed_load_o <= 1'b1;
               busy_o <= 1'b1;
            end
            LOAD: begin
               presc <= '0;
               chip <= '0;
               idx <= '0;
               state <= PREAMBLE_BITS > 0 ? PREAMBLE : DATA;
               bit_o <= PREAMBLE_BITS > 0 ? 1'b1 : shift[DATA_BITS-1];
            end
            // Next preamble bit is NOT(idx+1)[0], which equals idx[0].
            PREAMBLE: if (bit_end) begin
               idx <= idx == PRE_LAST ? '0 : idx + 1'b1;
               state <= idx == PRE_LAST ? DATA : PREAMBLE;
               bit_o <= idx == PRE_LAST ? shift[DATA_BITS-1] : idx[0];
            end
            DATA: if (bit_end) begin
               idx <= idx == DATA_LAST ? '0 : idx + 1'b1;
               shift <= shifted;
               state <= idx == DATA_LAST ? DONE : DATA;
               bit_o <= idx == DATA_LAST ? 1'b0 : shifted[DATA_BITS-1];
               busy_o <= idx != DATA_LAST;
               done_o <= idx == DATA_LAST;
            end
            default: state <= IDLE;
         endcase
         if (abort_i && busy_o) begin
            state <= IDLE;
            busy_o <= 1'b0;
            bit_o <= 1'b0;
            done_o <= 1'b0;
         end
      end
   end
endmodule
